// File: rtl/rcmd_pkg.sv
// ----------------------------------------------------------------------------
// rcmd_pkg : shared types and helpers for the DMA read command generator. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rcmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_DATA  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_CHK   = 3'd4
   } state_t;

   localparam int BYTE_W = 8;

   // Number of 32b beats covering a line that starts at byte lane 'shift'.
   function automatic logic [16:0] beat_cnt(input logic [1:0] shift, input logic [15:0] xsize);
      logic [16:0] span;
      span = {15'd0, shift} + {1'b0, xsize};
      return (span >> 2) + 17'd1;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] shift);
      return 4'b1111 << shift;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rcmd_gen_if.sv
// ----------------------------------------------------------------------------
// rcmd_gen_if : DMA read request/data bus plus shared data FIFO write port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rcmd_gen_if;
   logic        dma_r_req;
   logic        dma_r_ack;
   logic [31:0] dma_r_addr;
   logic [15:0] dma_r_len;
   logic        dma_r_dvld;
   logic [31:0] dma_rdata;
   logic        dma_r_dack;
   logic        buf_wr;
   logic [31:0] buf_wdata;
   logic [5:0]  buf_free_word;
   logic        buf_full;

   modport master (
      output dma_r_req, dma_r_addr, dma_r_len, dma_r_dack, buf_wr, buf_wdata,
      input  dma_r_ack, dma_r_dvld, dma_rdata, buf_free_word, buf_full
   );

   modport slave (
      input  dma_r_req, dma_r_addr, dma_r_len, dma_r_dack, buf_wr, buf_wdata,
      output dma_r_ack, dma_r_dvld, dma_rdata, buf_free_word, buf_full
   );
endinterface

`default_nettype wire

// File: rtl/rdata_packer.sv
// ----------------------------------------------------------------------------
// rdata_packer : drops misaligned leading bytes and packs read beats LSB-first. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rdata_packer
   import rcmd_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        start,
   input  wire logic        beat,
   input  wire logic        first,
   input  wire logic        last,
   input  wire logic        flush_go,
   input  wire logic [1:0]  shift,
   input  wire logic [16:0] remain,
   input  wire logic [31:0] rdata,
   output logic      [2:0]  nb,
   output logic             flush_need,
   output logic             wr,
   output logic      [31:0] wdata
);

   logic [23:0] resid;
   logic [1:0]  rcnt;

   logic [1:0]  lane_sh;
   logic [2:0]  nb_raw;
   logic [3:0]  lm;
   logic [31:0] lanes;
   logic [31:0] dropped;
   logic [31:0] cap_mask;
   logic [31:0] data;
   logic [55:0] merged;
   logic [2:0]  total;

   assign lane_sh = first ? shift : 2'd0;
   assign nb_raw  = 3'd4 - {1'b0, lane_sh};
   assign nb      = (remain < {14'd0, nb_raw}) ? remain[2:0] : nb_raw;
   assign lm      = lane_mask(lane_sh);

   always_comb begin
      lanes = '0;
      for (int i = 0; i < 4; i++) begin
         lanes[i*BYTE_W +: BYTE_W] = {BYTE_W{lm[i]}};
      end
   end

   // Bytes beyond the line end are zeroed so every written word is zero-padded.
   assign dropped  = (rdata & lanes) >> (BYTE_W * lane_sh);
   assign cap_mask = 32'hFFFF_FFFF >> (BYTE_W * (3'd4 - nb));
   assign data     = dropped & cap_mask;
   assign merged   = {32'd0, resid} | ({24'd0, data} << (BYTE_W * rcnt));
   assign total    = {1'b0, rcnt} + nb;

   assign flush_need = beat && last && (total > 3'd4);
   assign wr         = (beat && (total[2] || last)) || flush_go;
   assign wdata      = flush_go ? {8'd0, resid} :
                       (wr      ? merged[31:0]  : 32'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resid <= '0;
         rcnt  <= '0;
      end else if (start || flush_go) begin
         resid <= '0;
         rcnt  <= '0;
      end else if (beat) begin
         if (last && !flush_need) begin
            resid <= '0;
            rcnt  <= '0;
         end else if (total[2]) begin
            resid <= merged[55:32];
            rcnt  <= total[1:0];
         end else begin
            resid <= merged[23:0];
            rcnt  <= total[1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rcmd_gen.sv
// ----------------------------------------------------------------------------
// rcmd_gen : splits a 2D DMA read into 1D requests and packs returned beats. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rcmd_gen
   import rcmd_pkg::*;
#(
   parameter logic [5:0] BUF_THRES = 6'd2
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        dma_cmd_sof,
   output logic             dma_cmd_end,
   input  wire logic [31:0] cfg_sar,
   input  wire logic [15:0] cfg_trans_xsize,
   input  wire logic [15:0] cfg_trans_ysize,
   input  wire logic [15:0] cfg_sa_ystep,
   input  wire logic        dma_busy,
   rcmd_gen_if.master       bus,
   output logic             rx_err,
   input  wire logic        clr_rx_err
);

   state_t      state, state_nx;

   logic [31:0] addr;
   logic [15:0] ycnt;
   logic [15:0] xsize_q;
   logic [15:0] ystep_q;
   logic [1:0]  shift;
   logic [16:0] beats;
   logic [16:0] remain;
   logic        first;

   logic        req_w, ack_hs, dack_w, beat_acc, last_beat, flush_go, line_done;
   logic [2:0]  pk_nb;
   logic        pk_flush_need, pk_wr;
   logic [31:0] pk_wdata;

   assign req_w     = (state == ST_REQ) && dma_busy && (bus.buf_free_word >= BUF_THRES);
   assign ack_hs    = req_w && bus.dma_r_ack;
   assign dack_w    = (state == ST_DATA) && !bus.buf_full;
   assign beat_acc  = dack_w && bus.dma_r_dvld;
   assign last_beat = (beats == 17'd1);
   assign flush_go  = (state == ST_FLUSH) && !bus.buf_full;
   assign line_done = (beat_acc && last_beat && !pk_flush_need) || flush_go;

   assign bus.dma_r_req  = req_w;
   assign bus.dma_r_addr = addr;
   assign bus.dma_r_len  = xsize_q;
   assign bus.dma_r_dack = dack_w;
   assign bus.buf_wr     = pk_wr;
   assign bus.buf_wdata  = pk_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (dma_cmd_sof && dma_busy) state_nx = ST_REQ;
         ST_REQ: begin
            if (!dma_busy)   state_nx = ST_IDLE;
            else if (ack_hs) state_nx = ST_DATA;
         end
         ST_DATA: begin
            if (beat_acc && last_beat) begin
               if (pk_flush_need)      state_nx = ST_FLUSH;
               else if (ycnt == 16'd0) state_nx = ST_IDLE;
               else                    state_nx = ST_CHK;
            end
         end
         ST_FLUSH: begin
            if (flush_go) state_nx = (ycnt == 16'd0) ? ST_IDLE : ST_CHK;
         end
         ST_CHK:   state_nx = dma_busy ? ST_REQ : ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr        <= '0;
         ycnt        <= '0;
         xsize_q     <= '0;
         ystep_q     <= '0;
         shift       <= '0;
         beats       <= '0;
         remain      <= '0;
         first       <= 1'b0;
         dma_cmd_end <= 1'b0;
         rx_err      <= 1'b0;
      end else begin
         dma_cmd_end <= 1'b0;
         if (state == ST_IDLE && dma_cmd_sof && dma_busy) begin
            addr    <= cfg_sar;
            ycnt    <= cfg_trans_ysize;
            xsize_q <= cfg_trans_xsize;
            ystep_q <= cfg_sa_ystep;
         end
         if (ack_hs) begin
            shift  <= addr[1:0];
            beats  <= beat_cnt(addr[1:0], xsize_q);
            remain <= {1'b0, xsize_q} + 17'd1;
            first  <= 1'b1;
         end
         if (beat_acc) begin
            beats  <= beats - 17'd1;
            remain <= remain - {14'd0, pk_nb};
            first  <= 1'b0;
         end
         if (line_done) begin
            if (ycnt == 16'd0) begin
               dma_cmd_end <= 1'b1;
            end else begin
               ycnt <= ycnt - 16'd1;
               addr <= addr + {16'd0, xsize_q} + 32'd1 + {16'd0, ystep_q};
            end
         end
         // Any beat arriving outside a line is a protocol error; set beats clear.
         if (bus.dma_r_dvld && state != ST_DATA) rx_err <= 1'b1;
         else if (clr_rx_err)                    rx_err <= 1'b0;
      end
   end

   rdata_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .start      (ack_hs),
      .beat       (beat_acc),
      .first      (first),
      .last       (last_beat),
      .flush_go   (flush_go),
      .shift      (shift),
      .remain     (remain),
      .rdata      (bus.dma_rdata),
      .nb         (pk_nb),
      .flush_need (pk_flush_need),
      .wr         (pk_wr),
      .wdata      (pk_wdata)
   );

endmodule

`default_nettype wire

// File: doc/rcmd_gen.md
Name: rcmd_gen

Overview:
Read-side counterpart of the DMA write command generator. Splits a 2D DMA read command into 1D DMA read requests on the DMA read interface and collects the returned 32b read beats. It drops the leading bytes set by source address misalignment and packs the byte stream LSB-first into 32b words in the shared data FIFO. Each 1D line starts on a new FIFO word, so the write side can drain ceil((xsize+1)/4) words per line.

Parameters:
BUF_THRES, 6'd2, minimum buf_free_word before a 1D request is issued (range 2..24)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
dma_cmd_sof  in  1  1T pulse, starts a 2D read
dma_cmd_end  out  1  1T pulse, 2D read complete
cfg_sar  in  32  source start address
cfg_trans_xsize  in  16  line byte length, cnt from 0
cfg_trans_ysize  in  16  line count, cnt from 0
cfg_sa_ystep  in  16  gap bytes between lines
dma_busy  in  1  channel enabled
dma_r_req  out  1  1D read request
dma_r_ack  in  1  request accepted
dma_r_addr  out  32  1D byte address
dma_r_len  out  16  = cfg_trans_xsize
dma_r_dvld  in  1  read beat valid
dma_rdata  in  32  word-aligned read beat, byte0 = LSB
dma_r_dack  out  1  beat accepted when dvld & dack
buf_wr  out  1  FIFO write strobe
buf_wdata  out  32  packed word
buf_free_word  in  6  free 32b slots in FIFO
buf_full  in  1  FIFO full
rx_err  out  1  sticky protocol error
clr_rx_err  in  1  clears rx_err

Behaviour:
- Reset values: state IDLE; all outputs 0; addr, counters and residual bytes 0.
- States: IDLE, REQ, DATA, FLUSH, CHK.
- IDLE: on dma_cmd_sof & dma_busy, latch addr=cfg_sar and ycnt=cfg_trans_ysize, then go to REQ. sof is ignored in any other state.
- REQ: dma_r_req=1 only while buf_free_word >= BUF_THRES. req holds until ack; addr and len stay stable while req is high.
- On req&ack: latch shift=addr[1:0]; beats = ((shift + xsize) >> 2) + 1 (17b); remain = xsize+1 (17b); rcnt=0; go to DATA.
- DATA: dma_r_dack = !buf_full & !flush_pending.
  - Valid bytes per beat: first beat takes bytes [3:shift]; later beats take up to 4; every beat is capped by remain.
  - total = rcnt + nb (≤7). If total ≥ 4, write the low 4 bytes; the remaining total−4 bytes become the residual.
- Last beat (beats reaches 0):
  - total ≤ 4: single write, zero-padded above.
  - 4 < total: write the full word this cycle, go to FLUSH, and write the zero-padded residual next cycle (dack=0 in FLUSH).
  - total == 0 cannot occur.
- After the final write of a line: if ycnt==0, go to IDLE and pulse dma_cmd_end the same cycle the state changes. Otherwise decrement ycnt, set addr = line_addr + xsize + 1 + ystep (32b wrap), and go to CHK.
- CHK: if dma_busy, go to REQ; if !dma_busy, go to IDLE with no cmd_end.
- dma_busy low in REQ before ack: drop req and go to IDLE. dma_busy low in DATA or FLUSH: finish the line first (the beats are owed).
- buf_wr asserts only when !buf_full; the FLUSH write waits while buf_full.
- rx_err is set by dvld outside DATA; clr_rx_err clears it. Set wins on the same cycle. rx_err is cleared only by rst or clr.
- rst mid-transfer returns to IDLE immediately; any outstanding bus beats are then flagged via rx_err.

Decomposition:
- Package rcmd_pkg: state enum, BYTE_W=8, function beat_cnt(shift, xsize), function lane_mask(shift).
- Sub-module rdata_packer: residual register (3 bytes + rcnt) and the byte-shift/merge, pack/flush datapath. The FSM and address logic stay in rcmd_gen.

Test Plan:
- sar=0x100, xsize=7, ysize=0, beats 0x03020100, 0x07060504 -> one req addr 0x100 len 7; writes 0x03020100, 0x07060504; cmd_end 1T after the second write.
- sar=0x101, xsize=3, beats 0x44332211, 0x88776655 -> 2 beats; single write 0x55443322.
- sar=0x103, xsize=4, beats 0xDDCCBBAA, 0x44332211 -> writes 0x332211DD then 0x00000044; dack=0 in the FLUSH cycle.
- sar=0x200, xsize=3, ysize=2, ystep=0x10 -> req addrs 0x200, 0x214, 0x228; three writes; one cmd_end.
- buf_full held 5 cycles mid-line (xsize=15, aligned) -> dack=0 and no buf_wr during the stall; four writes in order, no loss or duplication.
- dvld pulse in IDLE -> rx_err=1; clr_rx_err -> 0. rst asserted in DATA -> all outputs 0 asynchronously; next sof restarts cleanly.
